// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan
//  Purpose  : 4x4 matrix keypad scanner with debounced press/release
//             detection on a slow scan clock. One column is driven low per
//             4-clock slot; rows are synchronized and sampled once per slot.
//  Ports    : clk_lo_freq  in   scan clock, rising edge
//             rst          in   synchronous active-high reset
//             row_pin[3:0] in   rows, active low, asynchronous
//             col_pin[3:0] out  column drive, exactly one bit low
//             key_code[3:0]out  {row_idx, col_idx} of last accepted key
//             key_valid    out  one-clock strobe per accepted key event
//             key_held     out  accepted key still pressed
//  Options  : KEYPAD_REPEAT_EN - auto-repeat key_valid while a key is held
//             (REPEAT_DLY slots to first repeat, REPEAT_PER slots after)
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_scan #(
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_DLY   = 32,
    parameter int REPEAT_PER   = 8
) (
    input  logic       clk_lo_freq,
    input  logic       rst,
    input  logic [3:0] row_pin,
    output logic [3:0] col_pin,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] c_deb_cnt   = 4'(DEBOUNCE_CNT);
    localparam logic [3:0] c_rows_idle = 4'b1111;

    // Parameter sanity checks resolved at elaboration.
    if (DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15) begin : g_bad_debounce
        $error("keypad_scan: DEBOUNCE_CNT must be 1..15");
    end
    if (REPEAT_DLY < 1 || REPEAT_DLY > 255 || REPEAT_PER < 1 || REPEAT_PER > 255) begin : g_bad_repeat
        $error("keypad_scan: REPEAT_DLY/REPEAT_PER must be 1..255");
    end

    // Registered state
    state_t     r_state;
    logic [3:0] r_sync_meta;
    logic [3:0] r_row_sync;
    logic [1:0] r_slot;
    logic [1:0] r_col_idx;
    logic [1:0] r_row_idx;
    logic [3:0] r_pattern;
    logic [3:0] r_deb_cnt;
    logic [3:0] r_key_code;
    logic       r_key_valid;

    // Next-state values
    state_t     w_state_next;
    logic [1:0] w_col_idx_next;
    logic [1:0] w_row_idx_next;
    logic [3:0] w_pattern_next;
    logic [3:0] w_deb_cnt_next;
    logic [3:0] w_key_code_next;
    logic       w_key_valid_next;

    logic       w_sample;
    logic       w_rows_idle;
    logic [3:0] w_deb_inc;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] c_rep_dly = 8'(REPEAT_DLY);
    localparam logic [7:0] c_rep_per = 8'(REPEAT_PER);
    logic [7:0] r_rep_cnt;
    logic       r_rep_first;
    logic [7:0] w_rep_cnt_next;
    logic       w_rep_first_next;
    logic [7:0] w_rep_inc;
    assign w_rep_inc = r_rep_cnt + 8'd1;
`endif

    // Rows are only trusted on the last clock of a slot, giving the freshly
    // driven column three clocks to propagate through the synchronizer.
    assign w_sample    = (r_slot == 2'd3);
    assign w_rows_idle = (r_row_sync == c_rows_idle);
    assign w_deb_inc   = r_deb_cnt + 4'd1;

    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        if (!rows[0])      return 2'd0;
        else if (!rows[1]) return 2'd1;
        else if (!rows[2]) return 2'd2;
        else               return 2'd3;
    endfunction

    always_comb begin
        w_state_next     = r_state;
        w_col_idx_next   = r_col_idx;
        w_row_idx_next   = r_row_idx;
        w_pattern_next   = r_pattern;
        w_deb_cnt_next   = r_deb_cnt;
        w_key_code_next  = r_key_code;
        w_key_valid_next = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        w_rep_cnt_next   = r_rep_cnt;
        w_rep_first_next = r_rep_first;
`endif
        if (w_sample) begin
            case (r_state)
                SCAN: begin
                    if (!w_rows_idle) begin
                        // Column stays frozen while this key is qualified.
                        w_row_idx_next = lowest_low_row(r_row_sync);
                        w_pattern_next = r_row_sync;
                        w_deb_cnt_next = 4'd1;
                        if (c_deb_cnt == 4'd1) begin
                            w_state_next     = PRESSED;
                            w_key_code_next  = {w_row_idx_next, r_col_idx};
                            w_key_valid_next = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            w_rep_cnt_next   = 8'd0;
                            w_rep_first_next = 1'b1;
`endif
                        end else begin
                            w_state_next = DEBOUNCE;
                        end
                    end else begin
                        w_col_idx_next = r_col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (r_row_sync == r_pattern) begin
                        w_deb_cnt_next = w_deb_inc;
                        if (w_deb_inc == c_deb_cnt) begin
                            w_state_next     = PRESSED;
                            w_key_code_next  = {r_row_idx, r_col_idx};
                            w_key_valid_next = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            w_rep_cnt_next   = 8'd0;
                            w_rep_first_next = 1'b1;
`endif
                        end
                    end else begin
                        w_state_next   = SCAN;
                        w_col_idx_next = r_col_idx + 2'd1;
                        w_deb_cnt_next = 4'd0;
                    end
                end
                PRESSED: begin
                    // Any non-idle pattern (including a second key on the
                    // frozen column) keeps the current key held.
                    if (w_rows_idle) begin
                        w_deb_cnt_next = 4'd1;
                        if (c_deb_cnt == 4'd1) begin
                            w_state_next   = SCAN;
                            w_col_idx_next = r_col_idx + 2'd1;
                            w_deb_cnt_next = 4'd0;
                        end else begin
                            w_state_next = RELEASE;
                        end
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (w_rep_inc == (r_rep_first ? c_rep_dly : c_rep_per)) begin
                            w_key_valid_next = 1'b1;
                            w_rep_cnt_next   = 8'd0;
                            w_rep_first_next = 1'b0;
                        end else begin
                            w_rep_cnt_next = w_rep_inc;
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (w_rows_idle) begin
                        w_deb_cnt_next = w_deb_inc;
                        if (w_deb_inc == c_deb_cnt) begin
                            w_state_next   = SCAN;
                            w_col_idx_next = r_col_idx + 2'd1;
                            w_deb_cnt_next = 4'd0;
                        end
                    end else begin
                        // Chatter during release: back to held, no new event.
                        w_state_next   = PRESSED;
                        w_deb_cnt_next = 4'd0;
`ifdef KEYPAD_REPEAT_EN
                        w_rep_cnt_next   = 8'd0;
                        w_rep_first_next = 1'b1;
`endif
                    end
                end
                default: w_state_next = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk_lo_freq) begin
        if (rst) begin
            r_state     <= SCAN;
            r_sync_meta <= c_rows_idle;
            r_row_sync  <= c_rows_idle;
            r_slot      <= 2'd0;
            r_col_idx   <= 2'd0;
            r_row_idx   <= 2'd0;
            r_pattern   <= c_rows_idle;
            r_deb_cnt   <= 4'd0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= 8'd0;
            r_rep_first <= 1'b1;
`endif
        end else begin
            r_state     <= w_state_next;
            r_sync_meta <= row_pin;
            r_row_sync  <= r_sync_meta;
            r_slot      <= r_slot + 2'd1;
            r_col_idx   <= w_col_idx_next;
            r_row_idx   <= w_row_idx_next;
            r_pattern   <= w_pattern_next;
            r_deb_cnt   <= w_deb_cnt_next;
            r_key_code  <= w_key_code_next;
            r_key_valid <= w_key_valid_next;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= w_rep_cnt_next;
            r_rep_first <= w_rep_first_next;
`endif
        end
    end

    assign col_pin   = ~(4'b0001 << r_col_idx);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = (r_state == PRESSED) || (r_state == RELEASE);

endmodule
`default_nettype wire
